lstm_seq_ctrl: RTL and testbench

Sequencer that runs the combinational LSTM cell over an input sequence of length seq_len. It accepts one X sample per step through a valid/ready handshake and drives the cell inputs (X, previous c, previous h). It holds the cell inputs stable for a fixed settle window, then captures c_out/h_out as the recurrent state for the next step. Each step's h is emitted on a valid/ready output stream. It sits between the sample source and the downstream consumer, with lstm_cell instantiated alongside it.

---
 rtl/lstm_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps a combinational LSTM cell over a sequence of X samples.
// Each step takes one X sample, holds the cell inputs for SETTLE_CYCLES cycles,
// captures c/h as the recurrent state and emits h on a valid/ready stream.
// Optional build macro: LSTM_SEQ_FINAL_ONLY_EN -- only the final step's h is
// emitted. Intermediate steps still update h_data and the recurrent state.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRACT_WIDTH   = 8,
  parameter int SEQ_LEN_WIDTH = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SEQ_LEN_WIDTH-1:0] seq_len,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [DATA_WIDTH-1:0]    x_data,
  output logic [DATA_WIDTH-1:0]    cell_x,
  output logic [DATA_WIDTH-1:0]    cell_c_in,
  output logic [DATA_WIDTH-1:0]    cell_h_in,
  input  logic [DATA_WIDTH-1:0]    cell_c_out,
  input  logic [DATA_WIDTH-1:0]    cell_h_out,
  output logic                     h_valid,
  input  logic                     h_ready,
  output logic [DATA_WIDTH-1:0]    h_data,
  output logic                     h_last,
  output logic [SEQ_LEN_WIDTH-1:0] step_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Values are Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH but only moved, never computed on.
  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("lstm_seq_ctrl: SETTLE_CYCLES must be at least 1");
    end
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
      $error("lstm_seq_ctrl: FRACT_WIDTH must be smaller than DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_X = 2'd1,
    S_SETTLE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [SEQ_LEN_WIDTH-1:0] r_seq_len;
  logic [SEQ_LEN_WIDTH-1:0] r_step_idx;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0]    r_cell_x;
  logic [DATA_WIDTH-1:0]    r_c_state;
  logic [DATA_WIDTH-1:0]    r_h_state;
  logic [DATA_WIDTH-1:0]    r_h_data;
  logic                     r_h_last;
  logic                     r_done;

  logic w_start_ok;
  logic w_start_zero;
  logic w_x_hs;
  logic w_capture;
  logic w_h_hs;
  logic w_last_step;

  // The step being settled is the final one when its index reaches seq_len-1.
  assign w_last_step = (r_step_idx == SEQ_LEN_WIDTH'(r_seq_len - 1'b1));

  assign x_ready   = (r_state == S_WAIT_X);
  assign h_valid   = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign cell_x    = r_cell_x;
  assign cell_c_in = r_c_state;
  assign cell_h_in = r_h_state;
  assign h_data    = r_h_data;
  assign h_last    = r_h_last;
  assign step_idx  = r_step_idx;
  assign done      = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the handshake/capture strobes that steer the datapath.
  always_comb begin
    w_next       = r_state;
    w_start_ok   = 1'b0;
    w_start_zero = 1'b0;
    w_x_hs       = 1'b0;
    w_capture    = 1'b0;
    w_h_hs       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            w_start_ok = 1'b1;
            w_next     = S_WAIT_X;
          end else begin
            w_start_zero = 1'b1;
          end
        end
      end
      S_WAIT_X: begin
        if (x_valid) begin
          w_x_hs = 1'b1;
          w_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
`ifdef LSTM_SEQ_FINAL_ONLY_EN
          w_next    = w_last_step ? S_OUT : S_WAIT_X;
`else
          w_next    = S_OUT;
`endif
        end
      end
      S_OUT: begin
        if (h_ready) begin
          w_h_hs = 1'b1;
          w_next = r_h_last ? S_IDLE : S_WAIT_X;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sequence bookkeeping, cell input registers, recurrent state and h output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq_len  <= '0;
      r_step_idx <= '0;
      r_cnt      <= '0;
      r_cell_x   <= '0;
      r_c_state  <= '0;
      r_h_state  <= '0;
      r_h_data   <= '0;
      r_h_last   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (w_h_hs && r_h_last) || w_start_zero;

      if (w_start_ok) begin
        r_seq_len  <= seq_len;
        r_step_idx <= '0;
        r_cell_x   <= '0;
        r_c_state  <= '0;
        r_h_state  <= '0;
      end

      if (w_x_hs) begin
        r_cell_x <= x_data;
        r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
      end

      if ((r_state == S_SETTLE) && !w_capture) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        r_c_state <= cell_c_out;
        r_h_state <= cell_h_out;
        r_h_data  <= cell_h_out;
        r_h_last  <= w_last_step;
`ifdef LSTM_SEQ_FINAL_ONLY_EN
        if (!w_last_step) begin
          r_step_idx <= r_step_idx + 1'b1;
        end
`endif
      end

      if (w_h_hs && !r_h_last) begin
        r_step_idx <= r_step_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl with a stub cell (c_out = c_in + x, h_out = c_out).
// Expected h values are running sums of the X samples of each sequence.
module tb_lstm_seq_ctrl;

  localparam int DW = 16;
  localparam int SW = 8;
  localparam int SC = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [SW-1:0] seq_len;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic [DW-1:0] cell_x;
  logic [DW-1:0] cell_c_in;
  logic [DW-1:0] cell_h_in;
  logic [DW-1:0] cell_c_out;
  logic [DW-1:0] cell_h_out;
  logic          h_valid;
  logic          h_ready;
  logic [DW-1:0] h_data;
  logic          h_last;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          done;

  lstm_seq_ctrl #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(8), .SEQ_LEN_WIDTH(SW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
    .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_last(h_last),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  assign cell_c_out = cell_c_in + cell_x;
  assign cell_h_out = cell_c_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] h;
    logic [DW-1:0] x;
    logic          last;
    logic [SW-1:0] idx;
  } item_t;

  item_t         q[$];
  logic [DW-1:0] hlog[$];
  logic          lastlog[$];
  int            done_cnt = 0;
  logic          exp_done = 1'b0;
  logic          pv = 1'b0;
  logic [DW-1:0] ph = '0;
  logic          pl = 1'b0;
  logic [DW-1:0] xv [8];

  // Reference model: expected emitted h words for a sequence of len samples xv[0..len-1].
  task automatic expect_seq(input int len);
    logic [DW-1:0] sum;
    item_t it;
    sum = '0;
    for (int i = 0; i < len; i++) begin
      sum     = sum + xv[i];
      it.h    = sum;
      it.x    = xv[i];
      it.last = (i == len - 1);
      it.idx  = SW'(i);
`ifdef LSTM_SEQ_FINAL_ONLY_EN
      if (i == len - 1) q.push_back(it);
`else
      q.push_back(it);
`endif
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      exp_done = 1'b0;
      pv       = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      if (done) done_cnt++;
      if (pv) begin
        chk("hold_valid", 32'(h_valid), 1);
        chk("hold_data", 32'(h_data), 32'(ph));
        chk("hold_last", 32'(h_last), 32'(pl));
      end
      if (x_ready) begin
        chk("x_ready_busy", 32'(busy), 1);
        chk("x_ready_excl", 32'(h_valid), 0);
      end
      if (h_valid) begin
        chk("h_valid_busy", 32'(busy), 1);
        if (q.size() == 0) begin
          chk("unexpected_h_valid", 32'(h_valid), 0);
        end else begin
          chk("h_data", 32'(h_data), 32'(q[0].h));
          chk("h_last", 32'(h_last), 32'(q[0].last));
          chk("step_idx", 32'(step_idx), 32'(q[0].idx));
          chk("cell_x", 32'(cell_x), 32'(q[0].x));
          chk("cell_c_in", 32'(cell_c_in), 32'(q[0].h));
        end
        if (h_ready) begin
          hlog.push_back(h_data);
          lastlog.push_back(h_last);
          if (q.size() != 0) void'(q.pop_front());
        end
      end
      exp_done = (h_valid && h_ready && h_last) || (!busy && start && (seq_len == '0));
      pv = h_valid && !h_ready;
      ph = h_data;
      pl = h_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input int len);
    start   = 1'b1;
    seq_len = SW'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic send_x(input logic [DW-1:0] v);
    int b;
    b       = 0;
    x_valid = 1'b1;
    x_data  = v;
    @(negedge clk);
    while (!x_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!x_ready) chk("x_ready_timeout", 32'(x_ready), 1);
    tick();
    x_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge clk);
    while (busy && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("idle_timeout", 32'(busy), 0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x_ready"}, 32'(x_ready), 0);
    chk({tag, "_h_valid"}, 32'(h_valid), 0);
    chk({tag, "_h_last"}, 32'(h_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_step_idx"}, 32'(step_idx), 0);
    chk({tag, "_cell_x"}, 32'(cell_x), 0);
    chk({tag, "_cell_c_in"}, 32'(cell_c_in), 0);
    chk({tag, "_cell_h_in"}, 32'(cell_h_in), 0);
    chk({tag, "_h_data"}, 32'(h_data), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    rst     = 1'b0;
    start   = 1'b0;
    seq_len = '0;
    x_valid = 1'b0;
    x_data  = '0;
    h_ready = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Three steps of 0x0100 with the consumer always ready.
    for (int i = 0; i < 8; i++) xv[i] = 16'h0100;
    base = hlog.size();
    expect_seq(3);
    start_seq(3);
    for (int i = 0; i < 3; i++) send_x(16'h0100);
    wait_idle();
    tick();
    chk("t2_done_cnt", 32'(done_cnt), 1);
`ifdef LSTM_SEQ_FINAL_ONLY_EN
    chk("t2_h_count", 32'(hlog.size() - base), 1);
    if (hlog.size() - base == 1) begin
      chk("t2_h0", 32'(hlog[base]), 32'h0300);
      chk("t2_last0", 32'(lastlog[base]), 1);
    end
`else
    chk("t2_h_count", 32'(hlog.size() - base), 3);
    if (hlog.size() - base == 3) begin
      chk("t2_h0", 32'(hlog[base]), 32'h0100);
      chk("t2_h1", 32'(hlog[base+1]), 32'h0200);
      chk("t2_h2", 32'(hlog[base+2]), 32'h0300);
      chk("t2_last0", 32'(lastlog[base]), 0);
      chk("t2_last1", 32'(lastlog[base+1]), 0);
      chk("t2_last2", 32'(lastlog[base+2]), 1);
    end
`endif

    // Latency and backpressure on a single-step sequence.
    xv[0]   = 16'h0050;
    h_ready = 1'b0;
    expect_seq(1);
    start_seq(1);
    x_valid = 1'b1;
    x_data  = 16'h0050;
    @(negedge clk);
    chk("t3_x_ready", 32'(x_ready), 1);
    tick();
    x_valid = 1'b0;
    @(negedge clk);
    chk("t3_e0_x_ready", 32'(x_ready), 0);
    chk("t3_e0_h_valid", 32'(h_valid), 0);
    chk("t3_e0_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t3_e1_h_valid", 32'(h_valid), 0);
    chk("t3_e1_x_ready", 32'(x_ready), 0);
    @(negedge clk);
    chk("t3_e2_h_valid", 32'(h_valid), 1);
    chk("t3_e2_h_data", 32'(h_data), 32'h0050);
    chk("t3_e2_h_last", 32'(h_last), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_h_valid", 32'(h_valid), 1);
      chk("t4_h_data", 32'(h_data), 32'h0050);
      chk("t4_h_last", 32'(h_last), 1);
      chk("t4_x_ready", 32'(x_ready), 0);
      chk("t4_step_idx", 32'(step_idx), 0);
    end
    tick();
    h_ready = 1'b1;
    wait_idle();
    tick();
    chk("t3_done_cnt", 32'(done_cnt), 2);

    // start and seq_len changes while busy must be ignored.
    xv[0] = 16'h0010;
    xv[1] = 16'h0020;
    xv[2] = 16'h0030;
    base  = hlog.size();
    expect_seq(3);
    start_seq(3);
    start   = 1'b1;
    seq_len = 8'd5;
    send_x(16'h0010);
    start   = 1'b0;
    send_x(16'h0020);
    send_x(16'h0030);
    wait_idle();
    tick();
    chk("t5_done_cnt", 32'(done_cnt), 3);
    chk("t5_h_final", 32'(hlog[hlog.size()-1]), 32'h0060);
    chk("t5_last_final", 32'(lastlog[lastlog.size()-1]), 1);

    // A fresh start after done clears the recurrent state.
    xv[0] = 16'h0100;
    xv[1] = 16'h0100;
    base  = hlog.size();
    expect_seq(2);
    start_seq(2);
    send_x(16'h0100);
    send_x(16'h0100);
    wait_idle();
    tick();
`ifdef LSTM_SEQ_FINAL_ONLY_EN
    chk("t5_restart_h", 32'(hlog[base]), 32'h0200);
`else
    chk("t5_restart_h", 32'(hlog[base]), 32'h0100);
`endif

    // Zero-length sequence: one done pulse and no h.
    dbase = done_cnt;
    base  = hlog.size();
    start_seq(0);
    repeat (4) tick();
    chk("t5_zero_done", 32'(done_cnt - dbase), 1);
    chk("t5_zero_h", 32'(hlog.size() - base), 0);
    chk("t5_zero_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of SETTLE abandons the sequence.
    xv[0] = 16'h0200;
    xv[1] = 16'h0200;
    expect_seq(2);
    start_seq(2);
    send_x(16'h0200);
    chk("t1_pre_cell_x", 32'(cell_x), 32'h0200);
    rst = 1'b0;
    #1;
    chk_all_zero("t1_async");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t1_post_busy", 32'(busy), 0);
    chk("t1_post_x_ready", 32'(x_ready), 0);
    repeat (3) tick();
    chk("t1_idle_busy", 32'(busy), 0);
    xv[0] = 16'h0100;
    expect_seq(1);
    start_seq(1);
    send_x(16'h0100);
    wait_idle();
    tick();
    chk("t1_after_h", 32'(hlog[hlog.size()-1]), 32'h0100);
    chk("t1_queue_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
